fifo_ptr_ctrl: RTL and testbench

Parametrised read/write pointer controller for the FIFO buffer. Holds the write and read address pointers, each extended with a phase (wrap) bit, and derives full, empty, occupancy and threshold flags from them. Supports any depth up to 2^AW, not only powers of two. Sits between the FIFO's push/pop interface and its storage array, driving the array's write and read addresses.

---
 rtl/fifo_ptr_ctrl.sv | 141 ++++++++++++++
 tb/tb_fifo_ptr_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointer controller for a FIFO of any depth up to 2^AW, with phase bits, occupancy and flags.
// Optional sticky overflow/underflow flags are built when FIFO_PTR_ERR_EN is defined.
module fifo_ptr_ctrl #(
   parameter int AW       = 10,
   parameter int DEPTH    = 1024,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1
) (
   input  logic          clk,
   input  logic          Reset,
   input  logic          wr_en,
   input  logic          rd_en,
   input  logic          err_clr,
   output logic [AW-1:0] wr_ptr,
   output logic          wr_phase,
   output logic [AW-1:0] rd_ptr,
   output logic          rd_phase,
   output logic          wr_ack,
   output logic          rd_ack,
   output logic          full,
   output logic          empty,
   output logic          almost_full,
   output logic          almost_empty,
   output logic [AW:0]   count,
   output logic          overflow,
   output logic          underflow
);

   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
   localparam logic [AW:0]   AF_LVL   = (AW+1)'(AF_LEVEL);
   localparam logic [AW:0]   AE_LVL   = (AW+1)'(AE_LEVEL);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic          wr_phase_q, wr_phase_d;
   logic          rd_phase_q, rd_phase_d;
   logic [AW:0]   count_q, count_d;
   logic          ptr_equal;

   // Full and empty come only from registered pointers, never from the requests.
   assign ptr_equal = (wr_ptr_q == rd_ptr_q);
   assign empty     = ptr_equal & (wr_phase_q == rd_phase_q);
   assign full      = ptr_equal & (wr_phase_q != rd_phase_q);

   assign wr_ack = wr_en & ~full  & ~Reset;
   assign rd_ack = rd_en & ~empty & ~Reset;

   assign wr_ptr       = wr_ptr_q;
   assign wr_phase     = wr_phase_q;
   assign rd_ptr       = rd_ptr_q;
   assign rd_phase     = rd_phase_q;
   assign count        = count_q;
   assign almost_full  = (count_q >= AF_LVL);
   assign almost_empty = (count_q <= AE_LVL);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      wr_phase_d = wr_phase_q;
      rd_ptr_d   = rd_ptr_q;
      rd_phase_d = rd_phase_q;
      count_d    = count_q;
      // Pointers wrap at DEPTH-1 rather than at 2^AW so non-power-of-two depths work.
      if (wr_ack) begin
         if (wr_ptr_q == LAST_PTR) begin
            wr_ptr_d   = '0;
            wr_phase_d = ~wr_phase_q;
         end else begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
      end
      if (rd_ack) begin
         if (rd_ptr_q == LAST_PTR) begin
            rd_ptr_d   = '0;
            rd_phase_d = ~rd_phase_q;
         end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
      end
      case ({wr_ack, rd_ack})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         wr_ptr_q   <= '0;
         wr_phase_q <= 1'b0;
         rd_ptr_q   <= '0;
         rd_phase_q <= 1'b0;
         count_q    <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         wr_phase_q <= wr_phase_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_phase_q <= rd_phase_d;
         count_q    <= count_d;
      end
   end

`ifdef FIFO_PTR_ERR_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   // A new error in the same cycle as err_clr wins over the clear.
   always_comb begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (wr_en & full) begin
         overflow_d = 1'b1;
      end
      if (rd_en & empty) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign overflow       = 1'b0;
   assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Self-checking bench for fifo_ptr_ctrl (DEPTH=6, AW=3): directed steps then random traffic,
// compared against a model built from total push/pop counts.
module tb_fifo_ptr_ctrl;

   localparam int AW       = 3;
   localparam int DEPTH    = 6;
   localparam int AF_LEVEL = DEPTH - 1;
   localparam int AE_LEVEL = 1;
`ifdef FIFO_PTR_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_in;
   logic          wr_en;
   logic          rd_en;
   logic          err_clr;
   logic [AW-1:0] wr_ptr;
   logic          wr_phase;
   logic [AW-1:0] rd_ptr;
   logic          rd_phase;
   logic          wr_ack;
   logic          rd_ack;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;

   int tests_run    = 0;
   int tests_failed = 0;

   // Model state: occupancy is just pushes minus pops since the last reset.
   int m_wr_total = 0;
   int m_rd_total = 0;
   bit m_ov       = 1'b0;
   bit m_un       = 1'b0;

   fifo_ptr_ctrl #(
      .AW(AW), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)
   ) dut (
      .clk(clk), .Reset(rst_in), .wr_en(wr_en), .rd_en(rd_en), .err_clr(err_clr),
      .wr_ptr(wr_ptr), .wr_phase(wr_phase), .rd_ptr(rd_ptr), .rd_phase(rd_phase),
      .wr_ack(wr_ack), .rd_ack(rd_ack), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int m_count();
      return m_wr_total - m_rd_total;
   endfunction

   task automatic checkOutput();
      int c;
      c = m_count();
      check("wr_ptr",       32'(wr_ptr),       32'(m_wr_total % DEPTH));
      check("wr_phase",     32'(wr_phase),     32'((m_wr_total / DEPTH) % 2));
      check("rd_ptr",       32'(rd_ptr),       32'(m_rd_total % DEPTH));
      check("rd_phase",     32'(rd_phase),     32'((m_rd_total / DEPTH) % 2));
      check("count",        32'(count),        32'(c));
      check("full",         32'(full),         32'(c == DEPTH));
      check("empty",        32'(empty),        32'(c == 0));
      check("almost_full",  32'(almost_full),  32'(c >= AF_LEVEL));
      check("almost_empty", 32'(almost_empty), 32'(c <= AE_LEVEL));
      check("overflow",     32'(overflow),     32'(m_ov & ERR_EN));
      check("underflow",    32'(underflow),    32'(m_un & ERR_EN));
   endtask

   // Drive one cycle, check the combinational acks, then the registered state after the edge.
   task automatic applyStimulus(input bit w, input bit r, input bit c, input bit rs);
      bit wacc;
      bit racc;
      int cnt;
      wr_en   = w;
      rd_en   = r;
      err_clr = c;
      rst_in  = rs;
      #1;
      cnt  = m_count();
      wacc = !rs && w && (cnt < DEPTH);
      racc = !rs && r && (cnt > 0);
      check("wr_ack", 32'(wr_ack), 32'(wacc));
      check("rd_ack", 32'(rd_ack), 32'(racc));
      @(posedge clk);
      if (rs) begin
         m_wr_total = 0;
         m_rd_total = 0;
         m_ov       = 1'b0;
         m_un       = 1'b0;
      end else begin
         if (c) begin
            m_ov = 1'b0;
            m_un = 1'b0;
         end
         if (w && cnt == DEPTH) m_ov = 1'b1;
         if (r && cnt == 0)     m_un = 1'b1;
         if (wacc) m_wr_total++;
         if (racc) m_rd_total++;
      end
      #1;
      checkOutput();
   endtask

   initial begin
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      err_clr = 1'b0;
      rst_in  = 1'b1;

      // Reset held for two cycles
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);

      // Fill to full, then push+pop while full
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      check("full_after_fill", 32'(full), 32'd1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      check("count_after_full_rw", 32'(count), 32'd5);

      // Down to half full, then simultaneous traffic wraps both pointers
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      check("count_half_steady", 32'(count), 32'd3);

      // Drain, pop while empty, then clear the error flag
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      // Error set and clear in the same cycle: set wins
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

      // Reset mid-operation with count=4
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      check("count_after_reset", 32'(count), 32'd0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 63) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
